mem_bus_bridge: RTL and testbench
=================================

// Module: mem_bus_bridge
// PURPOSE
//  Memory-side stage directly downstream of the data cache controller. Accepts one 64-bit line request
//  (mem_req_type, from cache_data_structs.sv) and performs it as two 32-bit beats on the external memory
//  bus, low word first. Returns mem_res_type with a one-cycle ready pulse and, for reads, the assembled line.
// PARAMETERS
//  ADDR_W      32   byte-address width of mem_req.addr and bus_addr
//  TIMEOUT     255  max cycles to wait for bus_ack on one beat before abandoning (8-bit counter)
// PORTS
//  clk         in   1   single clock, all logic on posedge
//  rst         in   1   asynchronous, active-high reset
//  mem_req     in   struct  {rw, valid, addr[31:0], data[63:0]}; rw=1 write, valid=request strobe
//  mem_res     out  struct  {ready, data[63:0]}; ready=1-cycle completion pulse
//  bus_valid   out  1   beat request, held until bus_ack
//  bus_we      out  1   1=write beat, 0=read beat
//  bus_addr    out  32  beat byte address, 4-byte aligned
//  bus_wdata   out  32  write data for current beat
//  bus_ack     in   1   beat complete; bus_rdata valid same cycle on reads
//  bus_rdata   in   32  read data
//  bus_err     out  1   sticky: a beat timed out; cleared only by rst
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; mem_res.ready=0, mem_res.data=0, bus_valid=0, bus_we=0,
//   bus_addr=0, bus_wdata=0, bus_err=0, timeout counter=0, captured request registers=0.
//  FSM states: IDLE, BEAT0, BEAT1, RESP.
//  IDLE: on mem_req.valid capture rw, addr with bits[2:0] forced to 0, and data; -> BEAT0 next cycle.
//  BEAT0: bus_valid=1, bus_we=rw, bus_addr=base, bus_wdata=data[31:0]. On bus_ack: read stores
//   bus_rdata in line[31:0]; -> BEAT1.
//  BEAT1: same, bus_addr=base+4, bus_wdata=data[63:32]; on bus_ack read stores line[63:32]; -> RESP.
//  RESP: mem_res.ready=1 for exactly this cycle; mem_res.data=assembled line (reads) or captured write
//   data (writes); -> IDLE. A mem_req.valid seen in RESP is captured -> BEAT0 (back-to-back, so a
//   write-back followed immediately by its allocate read loses no cycle).
//  mem_req.valid in BEAT0/BEAT1 is ignored; the controller only strobes valid when idle or on ready.
//  All bus_* outputs and mem_res are registered; bus_valid deasserts the cycle after bus_ack.
//  Latency: valid at cycle N, first bus_valid at N+1; with ack on first cycle of each beat,
//   mem_res.ready at N+3. Each wait cycle on a beat adds one cycle.
//  mem_res.data holds its value outside RESP until the next RESP (not cleared).
//  Timeout: counter resets at each beat start, increments per cycle with bus_valid=1 and no bus_ack.
//   Reaching TIMEOUT: set bus_err, drop bus_valid, go to RESP (ready still pulsed so controller
//   never hangs); unreceived read words are returned as 0.
//  bus_ack while bus_valid=0 is ignored. Beat order is always low then high; no wrap/burst modes.
//  rst asserted mid-transaction aborts immediately; no partial state survives.
// TESTING
//  1. Read addr 0x0000_1234, ack 1st cycle, rdata 0xAAAA_0001 then 0xBBBB_0002 -> bus_addr 0x1230 then
//     0x1234, ready at N+3, mem_res.data=0xBBBB_0002_AAAA_0001.
//  2. Write addr 0x40 data 0x1122_3344_5566_7788 -> beats (0x40,0x5566_7788),(0x44,0x1122_3344), bus_we=1,
//     one ready pulse.
//  3. Write-back then read strobed in RESP cycle -> second BEAT0 starts next cycle, two ready pulses.
//  4. ack delayed 3 cycles on BEAT1 -> bus_valid/addr/wdata stable throughout, ready at N+6.
//  5. No ack on BEAT0, TIMEOUT=4 -> bus_err=1 after 4 wait cycles, ready pulse, data=0, bus_err stays 1.
//  6. rst pulsed during BEAT1 -> all outputs 0 same cycle; next request runs normally from BEAT0.

Source files
------------

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
//   Memory-side stage below the data cache controller. Takes one 64-bit line
//   request and performs it as two 32-bit beats on the external bus, low word
//   first. It then returns a one-cycle ready pulse. For reads, the pulse comes
//   with the assembled line.
//
// Ports
//   clk            in   clock, all logic on posedge
//   rst            in   asynchronous active-high reset
//   mem_req_rw     in   1 = write line, 0 = read line
//   mem_req_valid  in   request strobe (sampled in IDLE and RESP only)
//   mem_req_addr   in   line byte address, bits [2:0] ignored
//   mem_req_data   in   write line data
//   mem_res_ready  out  one-cycle completion pulse
//   mem_res_data   out  read line / echoed write data, held until next RESP
//   bus_valid      out  beat request, held until bus_ack
//   bus_we         out  1 = write beat
//   bus_addr       out  beat byte address
//   bus_wdata      out  write data of current beat
//   bus_ack        in   beat complete, bus_rdata valid same cycle on reads
//   bus_rdata      in   read data
//   bus_err        out  sticky beat-timeout flag, cleared only by rst
//
// state | meaning
// IDLE  | no transaction, waiting for mem_req_valid
// BEAT0 | low word beat on the bus (base address)
// BEAT1 | high word beat on the bus (base + 4)
// RESP  | mem_res_ready pulsed, may accept the next request back-to-back
module mem_bus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_rw,
  input  logic              mem_req_valid,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [63:0]       mem_req_data,
  output logic              mem_res_ready,
  output logic [63:0]       mem_res_data,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  // The last wait cycle of a beat: the counter has already counted TIMEOUT-1
  // misses, so this miss makes TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state;
  logic                req_rw;
  logic [ADDR_W-1:0]   req_base;
  logic [63:0]         req_data;
  logic [31:0]         line_lo;
  logic [7:0]          tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_rw        <= 1'b0;
      req_base      <= '0;
      req_data      <= '0;
      line_lo       <= '0;
      tmo_cnt       <= '0;
      mem_res_ready <= 1'b0;
      mem_res_data  <= '0;
      bus_valid     <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_err       <= 1'b0;
    end else begin
      mem_res_ready <= 1'b0;
      case (state)
        IDLE, RESP: begin
          state <= IDLE;
          if (mem_req_valid) begin
            state     <= BEAT0;
            req_rw    <= mem_req_rw;
            req_base  <= {mem_req_addr[ADDR_W-1:3], 3'b000};
            req_data  <= mem_req_data;
            line_lo   <= '0;
            tmo_cnt   <= '0;
            bus_valid <= 1'b1;
            bus_we    <= mem_req_rw;
            bus_addr  <= {mem_req_addr[ADDR_W-1:3], 3'b000};
            bus_wdata <= mem_req_data[31:0];
          end
        end

        BEAT0: begin
          if (bus_ack) begin
            if (!req_rw) line_lo <= bus_rdata;
            state     <= BEAT1;
            tmo_cnt   <= '0;
            bus_addr  <= req_base + ADDR_W'(4);
            bus_wdata <= req_data[63:32];
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon the whole line; neither read word arrived.
            state         <= RESP;
            bus_err       <= 1'b1;
            bus_valid     <= 1'b0;
            mem_res_ready <= 1'b1;
            mem_res_data  <= req_rw ? req_data : 64'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        BEAT1: begin
          if (bus_ack) begin
            state         <= RESP;
            bus_valid     <= 1'b0;
            mem_res_ready <= 1'b1;
            mem_res_data  <= req_rw ? req_data : {bus_rdata, line_lo};
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= RESP;
            bus_err       <= 1'b1;
            bus_valid     <= 1'b0;
            mem_res_ready <= 1'b1;
            mem_res_data  <= req_rw ? req_data : {32'h0, line_lo};
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge. Inputs are driven and outputs sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_rw;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic        mem_res_ready;
  logic [63:0] mem_res_data;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;

  mem_bus_bridge #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_rw    (mem_req_rw),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_res_ready (mem_res_ready),
    .mem_res_data  (mem_res_data),
    .bus_valid     (bus_valid),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns at the negedge of the first
  // cycle after the request was sampled (BEAT0).
  task automatic send(input logic rw, input logic [31:0] addr, input logic [63:0] data);
    mem_req_rw    = rw;
    mem_req_addr  = addr;
    mem_req_data  = data;
    mem_req_valid = 1'b1;
    t0 = cyc;
    step();
    mem_req_valid = 1'b0;
  endtask

  // Serve one beat after `waits` cycles without ack, checking the beat is
  // stable every cycle it is presented.
  task automatic beat(input string tag, input logic [31:0] ea, input logic ewe,
                      input logic [31:0] ewd, input logic [31:0] rd, input int waits);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, ".valid"}, 64'(bus_valid), 64'd1);
      chk({tag, ".addr"},  64'(bus_addr),  64'(ea));
      chk({tag, ".we"},    64'(bus_we),    64'(ewe));
      chk({tag, ".wdata"}, 64'(bus_wdata), 64'(ewd));
      if (i == waits) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
      step();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'h0;
    mem_req_data  = 64'h0;
    bus_ack       = 1'b0;
    bus_rdata     = 32'h0;
    step();
    step();

    // Reset state
    chk("rst.valid", 64'(bus_valid), 64'd0);
    chk("rst.ready", 64'(mem_res_ready), 64'd0);
    chk("rst.data",  mem_res_data, 64'd0);
    chk("rst.addr",  64'(bus_addr), 64'd0);
    chk("rst.err",   64'(bus_err), 64'd0);
    rst = 1'b0;
    step();

    // 1: read, ack on first cycle of each beat
    send(1'b0, 32'h0000_1234, 64'h0);
    beat("t1.b0", 32'h0000_1230, 1'b0, 32'h0, 32'hAAAA_0001, 0);
    beat("t1.b1", 32'h0000_1234, 1'b0, 32'h0, 32'hBBBB_0002, 0);
    chk("t1.ready", 64'(mem_res_ready), 64'd1);
    chk("t1.lat",   64'(cyc - t0), 64'd3);
    chk("t1.data",  mem_res_data, 64'hBBBB_0002_AAAA_0001);
    chk("t1.bvld",  64'(bus_valid), 64'd0);
    step();
    chk("t1.ready_drop", 64'(mem_res_ready), 64'd0);
    chk("t1.data_hold",  mem_res_data, 64'hBBBB_0002_AAAA_0001);

    // 2: write
    send(1'b1, 32'h0000_0040, 64'h1122_3344_5566_7788);
    beat("t2.b0", 32'h0000_0040, 1'b1, 32'h5566_7788, 32'h0, 0);
    beat("t2.b1", 32'h0000_0044, 1'b1, 32'h1122_3344, 32'h0, 0);
    chk("t2.ready", 64'(mem_res_ready), 64'd1);
    chk("t2.data",  mem_res_data, 64'h1122_3344_5566_7788);
    step();
    chk("t2.ready_once", 64'(mem_res_ready), 64'd0);
    chk("t2.bvld",       64'(bus_valid), 64'd0);

    // 3: write-back, then read strobed in the RESP cycle
    send(1'b1, 32'h0000_0100, 64'hCAFE_0000_BEEF_0000);
    beat("t3.wb0", 32'h0000_0100, 1'b1, 32'hBEEF_0000, 32'h0, 0);
    beat("t3.wb1", 32'h0000_0104, 1'b1, 32'hCAFE_0000, 32'h0, 0);
    chk("t3.ready1", 64'(mem_res_ready), 64'd1);
    send(1'b0, 32'h0000_0200, 64'h0);
    chk("t3.ready1_drop", 64'(mem_res_ready), 64'd0);
    beat("t3.rd0", 32'h0000_0200, 1'b0, 32'h0, 32'h1357_9BDF, 0);
    beat("t3.rd1", 32'h0000_0204, 1'b0, 32'h0, 32'h2468_ACE0, 0);
    chk("t3.ready2", 64'(mem_res_ready), 64'd1);
    chk("t3.data2",  mem_res_data, 64'h2468_ACE0_1357_9BDF);
    step();

    // 4: ack delayed 3 cycles on BEAT1
    send(1'b1, 32'h0000_0300, 64'h0F0F_0F0F_F0F0_F0F0);
    beat("t4.b0", 32'h0000_0300, 1'b1, 32'hF0F0_F0F0, 32'h0, 0);
    beat("t4.b1", 32'h0000_0304, 1'b1, 32'h0F0F_0F0F, 32'h0, 3);
    chk("t4.ready", 64'(mem_res_ready), 64'd1);
    chk("t4.lat",   64'(cyc - t0), 64'd6);
    chk("t4.err",   64'(bus_err), 64'd0);
    step();

    // 5: no ack on BEAT0, TIMEOUT = 4
    send(1'b0, 32'h0000_0500, 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t5.wait_valid", 64'(bus_valid), 64'd1);
      chk("t5.wait_err",   64'(bus_err), 64'd0);
      step();
    end
    chk("t5.err",   64'(bus_err), 64'd1);
    chk("t5.ready", 64'(mem_res_ready), 64'd1);
    chk("t5.data",  mem_res_data, 64'h0);
    chk("t5.bvld",  64'(bus_valid), 64'd0);
    step();
    // A stray ack while idle must not start or finish anything.
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("t5.stray_ready", 64'(mem_res_ready), 64'd0);
    chk("t5.stray_bvld",  64'(bus_valid), 64'd0);
    send(1'b0, 32'h0000_0508, 64'h0);
    beat("t5.n0", 32'h0000_0508, 1'b0, 32'h0, 32'h0000_0011, 0);
    beat("t5.n1", 32'h0000_050C, 1'b0, 32'h0, 32'h0000_0022, 0);
    chk("t5.n_data", mem_res_data, 64'h0000_0022_0000_0011);
    chk("t5.sticky", 64'(bus_err), 64'd1);
    step();

    // 6: reset pulsed during BEAT1
    send(1'b1, 32'h0000_0600, 64'h7777_6666_5555_4444);
    beat("t6.b0", 32'h0000_0600, 1'b1, 32'h5555_4444, 32'h0, 0);
    chk("t6.in_b1", 64'(bus_addr), 64'h604);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_valid", 64'(bus_valid), 64'd0);
    chk("t6.rst_we",    64'(bus_we), 64'd0);
    chk("t6.rst_addr",  64'(bus_addr), 64'd0);
    chk("t6.rst_wdata", 64'(bus_wdata), 64'd0);
    chk("t6.rst_ready", 64'(mem_res_ready), 64'd0);
    chk("t6.rst_data",  mem_res_data, 64'd0);
    chk("t6.rst_err",   64'(bus_err), 64'd0);
    step();
    rst = 1'b0;
    step();
    send(1'b0, 32'h0000_0700, 64'h0);
    beat("t6.r0", 32'h0000_0700, 1'b0, 32'h0, 32'hDEAD_0001, 0);
    beat("t6.r1", 32'h0000_0704, 1'b0, 32'h0, 32'hDEAD_0002, 0);
    chk("t6.ready", 64'(mem_res_ready), 64'd1);
    chk("t6.data",  mem_res_data, 64'hDEAD_0002_DEAD_0001);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
